// File: rtl/rice_param_scheduler.sv
// Partition scheduler for the Rice encoder: buffers one partition, finds the cheapest
// Rice parameter k from exact per-k code lengths, then replays the partition with that k.
module rice_param_scheduler #(
  parameter int unsigned PARTITION_SIZE = 64,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned MAX_K          = 14
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [15:0] iSample,
  output logic        oReady,
  output logic        oEncValid,
  output logic [15:0] oEncSample,
  output logic [3:0]  oRiceParam,
  output logic        oParamValid,
  output logic [22:0] oCost
);

  localparam int unsigned SMP_W  = 16;
  localparam int unsigned ACC_W  = SMP_W + ADDR_W;
  localparam int unsigned COST_W = ACC_W + 1;
  localparam int unsigned K_W    = 4;

  typedef enum logic [1:0] {FILL, SELECT, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ACC_W-1:0]    acc_q [MAX_K+1];
  logic [ACC_W-1:0]    acc_d [MAX_K+1];
  logic [K_W-1:0]      best_k_q, best_k_d;
  logic [COST_W-1:0]   best_cost_q, best_cost_d;
  logic                ready_q, ready_d;
  logic                enc_valid_q, enc_valid_d;
  logic [SMP_W-1:0]    enc_sample_q, enc_sample_d;
  logic [K_W-1:0]      param_q, param_d;
  logic                param_valid_q, param_valid_d;
  logic [COST_W-1:0]   cost_q, cost_d;

  logic [SMP_W-1:0]    mem_q [PARTITION_SIZE];
  logic                we_c;
  logic                accept_c;
  logic [SMP_W-1:0]    fold_c;
  logic [COST_W-1:0]   cost_c;
  logic                take_c;
  logic [K_W-1:0]      sel_k_c;
  logic [COST_W-1:0]   sel_cost_c;

  // Zig-zag fold identical to the encoder's mapping of signed residuals.
  assign fold_c = iSample[SMP_W-1] ? ~{iSample[SMP_W-2:0], 1'b0} : {iSample[SMP_W-2:0], 1'b0};
  assign accept_c = iValid && ready_q && (state_q == FILL);

  // Cost of the k under evaluation; ties keep the earlier (smaller) k.
  assign cost_c     = COST_W'(acc_q[k_q]) + COST_W'((32'(k_q) + 32'd1) << ADDR_W);
  assign take_c     = (k_q == '0) || (cost_c < best_cost_q);
  assign sel_k_c    = take_c ? k_q : best_k_q;
  assign sel_cost_c = take_c ? cost_c : best_cost_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    k_d           = k_q;
    acc_d         = acc_q;
    best_k_d      = best_k_q;
    best_cost_d   = best_cost_q;
    param_d       = param_q;
    cost_d        = cost_q;
    enc_valid_d   = 1'b0;
    enc_sample_d  = '0;
    param_valid_d = 1'b0;
    we_c          = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept_c) begin
          we_c = 1'b1;
          for (int k = 0; k <= int'(MAX_K); k++) begin
            acc_d[k] = acc_q[k] + ACC_W'(fold_c >> k);
          end
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(PARTITION_SIZE - 1)) begin
            state_d = SELECT;
            k_d     = '0;
          end
        end
      end
      SELECT: begin
        best_k_d    = sel_k_c;
        best_cost_d = sel_cost_c;
        if (k_q == K_W'(MAX_K)) begin
          param_d = sel_k_c;
          cost_d  = sel_cost_c;
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DRAIN: begin
        // Synchronous buffer read lands directly in the output register.
        enc_valid_d   = 1'b1;
        enc_sample_d  = mem_q[idx_q];
        param_valid_d = (idx_q == '0);
        idx_d         = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(PARTITION_SIZE - 1)) begin
          for (int k = 0; k <= int'(MAX_K); k++) begin
            acc_d[k] = '0;
          end
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      k_q           <= '0;
      for (int k = 0; k <= int'(MAX_K); k++) begin
        acc_q[k] <= '0;
      end
      best_k_q      <= '0;
      best_cost_q   <= '0;
      ready_q       <= 1'b1;
      enc_valid_q   <= 1'b0;
      enc_sample_q  <= '0;
      param_q       <= '0;
      param_valid_q <= 1'b0;
      cost_q        <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      best_k_q      <= best_k_d;
      best_cost_q   <= best_cost_d;
      ready_q       <= ready_d;
      enc_valid_q   <= enc_valid_d;
      enc_sample_q  <= enc_sample_d;
      param_q       <= param_d;
      param_valid_q <= param_valid_d;
      cost_q        <= cost_d;
    end
  end

  // Single-port sample buffer: written during FILL, read during DRAIN at idx_q.
  always_ff @(posedge iClock) begin
    if (we_c) begin
      mem_q[idx_q] <= iSample;
    end
  end

  assign oReady      = ready_q;
  assign oEncValid   = enc_valid_q;
  assign oEncSample  = enc_sample_q;
  assign oRiceParam  = param_q;
  assign oParamValid = param_valid_q;
  assign oCost       = cost_q;

endmodule

// File: tb/tb_rice_param_scheduler.sv
// Directed bench for rice_param_scheduler: partitions with hand-computed best k and cost.
module tb_rice_param_scheduler;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iValid;
  logic [15:0] iSample;
  logic        oReady;
  logic        oEncValid;
  logic [15:0] oEncSample;
  logic [3:0]  oRiceParam;
  logic        oParamValid;
  logic [22:0] oCost;

  logic [15:0] pat [64];
  int          total = 0;
  int          bad   = 0;

  rice_param_scheduler dut (
    .iClock     (clk),
    .iReset     (iReset),
    .iValid     (iValid),
    .iSample    (iSample),
    .oReady     (oReady),
    .oEncValid  (oEncValid),
    .oEncSample (oEncSample),
    .oRiceParam (oRiceParam),
    .oParamValid(oParamValid),
    .oCost      (oCost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_pat(input logic [15:0] v);
    for (int i = 0; i < 64; i++) pat[i] = v;
  endtask

  // Called at a negedge; returns at the posedge that accepts the 64th sample.
  task automatic feed(input logic gaps);
    int   i   = 0;
    int   cyc = 0;
    logic rdy;
    while (i < 64) begin
      iValid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      iSample = pat[i];
      rdy     = oReady;
      @(posedge clk);
      if (iValid && rdy) i++;
      cyc++;
      if (cyc > 2000) begin
        chk("feed_timeout", i, 64);
        break;
      end
      if (i < 64) @(negedge clk);
    end
  endtask

  // Watches SELECT/DRAIN; cycle c is observed at the negedge after edge T+c.
  task automatic collect(input logic hold, input int stop, input int exp_k, input int exp_cost);
    int n = 0, first = -1, ord = 0, pv_bad = 0, gap = 0, rdy_bad = 0, last_rdy = 0, kbad = 0;
    for (int c = 1; c <= 120 && n < 64; c++) begin
      @(posedge clk);
      @(negedge clk);
      iValid  = hold;
      iSample = 16'h7777;
      if (oEncValid) begin
        if (first < 0) first = c;
        if (oEncSample !== pat[n]) ord++;
        if (oParamValid !== (n == 0)) pv_bad++;
        if (oRiceParam !== 4'(exp_k)) kbad++;
        n++;
      end else begin
        if (oParamValid) pv_bad++;
        if (first >= 0) gap++;
      end
      if (n < 64 && oReady !== 1'b0) rdy_bad++;
      if (n == 64) last_rdy = int'(oReady);
      if (stop > 0 && n == stop) return;
    end
    iValid = 1'b0;
    chk("first_latency", first, 16);
    chk("sample_count", n, 64);
    chk("order_errors", ord, 0);
    chk("param_valid_errors", pv_bad, 0);
    chk("param_unstable", kbad, 0);
    chk("drain_gaps", gap, 0);
    chk("ready_while_busy", rdy_bad, 0);
    chk("ready_after_drain", last_rdy, 1);
    chk("rice_param", int'(oRiceParam), exp_k);
    chk("cost", int'(oCost), exp_cost);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset  = 1'b0;
    iValid  = 1'b0;
    iSample = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(oReady), 1);
    chk("rst_enc_valid", int'(oEncValid), 0);
    chk("rst_param", int'(oRiceParam), 0);
    chk("rst_cost", int'(oCost), 0);
    @(negedge clk);
    iReset = 1'b1;
    @(negedge clk);

    fill_pat(16'h0000);
    feed(1'b0);
    collect(1'b0, 0, 0, 64);

    // 100 and 0 partitions back to back: ties k=7/k=8 at 576, then zeros.
    fill_pat(16'd100);
    feed(1'b0);
    collect(1'b0, 0, 7, 576);
    fill_pat(16'h0000);
    feed(1'b0);
    collect(1'b0, 0, 0, 64);

    fill_pat(16'hFFFF);
    feed(1'b0);
    collect(1'b0, 0, 0, 128);

    fill_pat(16'h8000);
    feed(1'b0);
    collect(1'b0, 0, 14, 1152);

    // Ramp 0..63 with gaps; iValid held high while busy. k=5 and k=6 tie at 480.
    for (int i = 0; i < 64; i++) pat[i] = 16'(i);
    feed(1'b1);
    collect(1'b1, 0, 5, 480);

    // Reset in the middle of a drain, then a clean zero partition.
    fill_pat(16'd100);
    feed(1'b0);
    collect(1'b0, 21, 7, 576);
    iReset = 1'b0;
    #1;
    chk("midrst_enc_valid", int'(oEncValid), 0);
    chk("midrst_param_valid", int'(oParamValid), 0);
    chk("midrst_param", int'(oRiceParam), 0);
    chk("midrst_cost", int'(oCost), 0);
    chk("midrst_sample", int'(oEncSample), 0);
    chk("midrst_ready", int'(oReady), 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_enc_valid", int'(oEncValid), 0);
    end
    iReset = 1'b1;
    @(negedge clk);
    fill_pat(16'h0000);
    feed(1'b0);
    collect(1'b0, 0, 0, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rice_param_scheduler.md
Name: rice_param_scheduler

Overview:
- Sequences residual samples into RiceEncoder0 one fixed-size partition at a time.
- Buffers each partition and computes the exact Rice code length for every parameter k.
- Selects the cheapest k, then replays the buffered samples to the encoder with that k held stable.
- Sits between the residual (LPC) stage and the Rice encoder. Provides the per-partition parameter and the stream framing.

Parameters:
- PARTITION_SIZE, 64, samples per partition; must be a power of two.
- ADDR_W, 6, log2(PARTITION_SIZE).
- MAX_K, 14, largest Rice parameter evaluated; k ranges 0..MAX_K.

Ports:
- iClock  input  1  clock.
- iReset  input  1  asynchronous active-low reset.
- iValid  input  1  input sample strobe; honoured only while oReady=1.
- iSample  input  16  signed residual.
- oReady  output  1  block can accept a sample this cycle.
- oEncValid  output  1  oEncSample valid for the encoder.
- oEncSample  output  16  buffered signed residual replayed to the encoder.
- oRiceParam  output  4  selected k; stable for the whole drain.
- oParamValid  output  1  one-cycle pulse coincident with the first oEncValid of a partition.
- oCost  output  23  total bits for the partition at the selected k; stable during drain.

Behaviour:
- Reset (iReset=0, asynchronous): state FILL, write index 0, all accumulators 0, oReady=1. oEncValid, oParamValid, oRiceParam, oCost and oEncSample all 0.
- Reset mid-operation discards the partial partition; no output occurs after release until a full new partition is received.
- Fold rule, matching the encoder: u = {s[14:0],0}, XORed with 16'hFFFF when s[15]=1. Examples: 0→0, -1→1, 1→2, -32768→65535.
- Cost per k: cost(k) = PARTITION_SIZE*(k+1) + Σ(u>>k).
  - MAX_K+1 accumulators, each 22 bits (16+ADDR_W).
  - cost is 23 bits; no overflow is possible.
- FILL state:
  - oReady=1.
  - On iValid: write iSample to buffer[idx]; add (u>>k) to acc[k] for every k; idx++.
  - On acceptance of the PARTITION_SIZE-th sample: idx wraps to 0; next state is SELECT.
- SELECT state:
  - oReady=0; iValid is ignored and no data is stored.
  - Evaluates one k per cycle, k=0..MAX_K (MAX_K+1 cycles).
  - Keeps the running minimum; strict less-than comparison, so ties resolve to the smaller k.
  - After k=MAX_K, registers oRiceParam and oCost; next state is DRAIN.
- DRAIN state:
  - oReady=0.
  - Reads buffer[0..PARTITION_SIZE-1] in order; one oEncValid per cycle with no gaps.
  - oParamValid=1 only on the first sample.
  - After the last sample: clear accumulators, idx=0; next state is FILL, with oReady=1 on the following cycle.
- Latency:
  - Last input accepted at edge T.
  - First oEncValid at edge T+MAX_K+2.
  - Last oEncValid at T+MAX_K+1+PARTITION_SIZE.
- No backpressure from the encoder; it accepts one sample per cycle.
- iValid gaps during FILL are allowed; idx advances only on accepted samples.
- Buffer is single-port, with synchronous read. The read is issued one cycle ahead so the output stream is gapless.
- oRiceParam and oCost hold their values after DRAIN until the next SELECT completes.

Test Plan:
- 64 samples of 0 → oRiceParam=0, oCost=64; 64 zeros replayed in order; oParamValid on the first sample only.
- 64 samples of 100 (u=200) → costs at k=7 and k=8 both 576; tie rule gives oRiceParam=7, oCost=576.
- 64 samples of -1 (u=1) → k=0 and k=1 both cost 128; oRiceParam=0, oCost=128. 64 samples of -32768 → oRiceParam=14, oCost=1152.
- Ramp 0..63 with random iValid gaps; iValid held high throughout SELECT/DRAIN → oReady=0 during SELECT/DRAIN and extra samples are dropped. Replay equals 0..63 exactly, first sample at T+16.
- Two back-to-back partitions (all 100, then all 0) → params 7 then 0. oReady rises the cycle after the last drain sample; no sample is lost between partitions.
- Assert iReset low at drain sample 20, release, send 64 zeros → outputs clear immediately. No stale samples appear; the next partition gives oRiceParam=0, oCost=64.
